// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus transfer controller: FSM states, source codes
// and default sizing.
package bus_xfer_pkg;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Same codes the arbiter uses for its a/b/c states.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC1     = 2'd1,
    SRC2     = 2'd2,
    SRC3     = 2'd3
  } src_t;

  function automatic logic [2:0] src_onehot(input src_t s);
    case (s)
      SRC1:    return 3'b001;
      SRC2:    return 3'b010;
      SRC3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/xfer_src_mux.sv
// Zero-cycle 3:1 selection of the offered data word and its last flag by
// source code; SRC_NONE yields zeros.
module xfer_src_mux
  import bus_xfer_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  src_t          src,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic          last1,
  input  logic          last2,
  input  logic          last3,
  output logic [DW-1:0] dsel,
  output logic          lsel
);
  always_comb begin
    dsel = '0;
    lsel = 1'b0;
    case (src)
      SRC1:    begin dsel = d1; lsel = last1; end
      SRC2:    begin dsel = d2; lsel = last2; end
      SRC3:    begin dsel = d3; lsel = last3; end
      default: ;
    endcase
  end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// Moves a burst of words from the granted requester onto a ready/valid bus,
// ending on the requester's last word or after MAX_BURST words.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gt1,
  input  logic          gt2,
  input  logic          gt3,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic          last1,
  input  logic          last2,
  input  logic          last3,
  input  logic          bus_ready,
  output logic [DW-1:0] bus_data,
  output logic          bus_valid,
  output logic [1:0]    bus_src,
  output logic          ack1,
  output logic          ack2,
  output logic          ack3,
  output logic          done1,
  output logic          done2,
  output logic          done3,
  output logic          err_multi,
  output logic          err_abort
);
  localparam int CW = $clog2(MAX_BURST) + 1;

  state_t        state, state_n;
  src_t          src, src_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          set_multi, set_abort;
  logic [DW-1:0] dsel;
  logic          lsel, gsel;
  logic [2:0]    src_oh, ack_v, done_v;
  logic [1:0]    ngt;

  xfer_src_mux #(.DW(DW)) u_mux (
    .src   (src),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .last1 (last1),
    .last2 (last2),
    .last3 (last3),
    .dsel  (dsel),
    .lsel  (lsel)
  );

  assign src_oh = src_onehot(src);
  assign gsel   = |(src_oh & {gt3, gt2, gt1});
  assign ngt    = 2'(gt1) + 2'(gt2) + 2'(gt3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      src       <= SRC_NONE;
      cnt       <= '0;
      err_multi <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state <= state_n;
      src   <= src_n;
      cnt   <= cnt_n;
      if (set_multi) err_multi <= 1'b1;
      if (set_abort) err_abort <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    src_n     = src;
    cnt_n     = cnt;
    set_multi = 1'b0;
    set_abort = 1'b0;
    bus_valid = 1'b0;
    bus_data  = '0;
    bus_src   = SRC_NONE;
    ack_v     = 3'b000;
    done_v    = 3'b000;
    case (state)
      ST_IDLE: begin
        if (ngt == 2'd1) begin
          src_n   = gt1 ? SRC1 : (gt2 ? SRC2 : SRC3);
          cnt_n   = '0;
          state_n = ST_XFER;
        end else if (ngt > 2'd1) begin
          set_multi = 1'b1;
        end
      end
      ST_XFER: begin
        bus_src = src;
        // A dropped grant wins over acceptance; valid is withheld so no
        // word can be taken without its ack.
        if (!gsel) begin
          set_abort = 1'b1;
          src_n     = SRC_NONE;
          state_n   = ST_IDLE;
        end else begin
          bus_valid = 1'b1;
          bus_data  = dsel;
          if (bus_ready) begin
            ack_v = src_oh;
            cnt_n = cnt + CW'(1);
            if (lsel || cnt == CW'(MAX_BURST - 1)) state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        bus_src = src;
        done_v  = src_oh;
        if (!gsel) begin
          src_n   = SRC_NONE;
          state_n = ST_IDLE;
        end
      end
      default: begin
        src_n   = SRC_NONE;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign {ack3, ack2, ack1}    = ack_v;
  assign {done3, done2, done1} = done_v;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed vector table, corner-case sequences and
// randomized traffic against a burst-level reference model.
module tb_bus_xfer_ctrl;
  localparam int DW = 8;
  localparam int MAXB = 4;

  typedef logic [18:0] out_t;  // {valid, data[7:0], src[1:0], ack3..1, done3..1, em, ea}
  typedef struct {
    logic       rst;
    logic [2:0] gt;
    logic [2:0] lst;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    gt  = '0;
  logic [2:0]    lst = '0;
  logic          rdy = 1'b0;
  logic [DW-1:0] dv [3];
  logic [DW-1:0] bus_data;
  logic          bus_valid;
  logic [1:0]    bus_src;
  logic          ack1, ack2, ack3, done1, done2, done3, err_multi, err_abort;
  out_t          dut_o;

  int nchk = 0;
  int nerr = 0;

  // Reference model: who owns the bus, how many words went out, whether the
  // burst has finished, plus the sticky errors.
  int m_owner, m_sent;
  bit m_fin, m_em, m_ea;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .gt1(gt[0]), .gt2(gt[1]), .gt3(gt[2]),
    .d1(dv[0]), .d2(dv[1]), .d3(dv[2]),
    .last1(lst[0]), .last2(lst[1]), .last3(lst[2]), .bus_ready(rdy),
    .bus_data(bus_data), .bus_valid(bus_valid), .bus_src(bus_src),
    .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .done1(done1), .done2(done2), .done3(done3),
    .err_multi(err_multi), .err_abort(err_abort)
  );

  assign dut_o = {bus_valid, bus_data, bus_src, ack3, ack2, ack1,
                  done3, done2, done1, err_multi, err_abort};

  function automatic out_t mk(input logic v, input logic [7:0] d, input logic [1:0] s,
                              input logic [2:0] a, input logic [2:0] dn,
                              input logic em, input logic ea);
    return {v, d, s, a, dn, em, ea};
  endfunction

  function automatic out_t model_out();
    logic v, g;
    logic [7:0] d;
    logic [2:0] a, dn;
    v = 1'b0; d = '0; a = '0; dn = '0;
    g = (m_owner != 0) ? gt[m_owner-1] : 1'b0;
    if (m_owner != 0 && !m_fin) begin
      v = g;
      if (g) d = dv[m_owner-1];
      if (g && rdy) a[m_owner-1] = 1'b1;
    end
    if (m_owner != 0 && m_fin) dn[m_owner-1] = 1'b1;
    return mk(v, d, 2'(m_owner), a, dn, m_em, m_ea);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_owner = 0; m_sent = 0; m_fin = 0; m_em = 0; m_ea = 0;
    end else if (m_owner == 0) begin
      if ($countones(gt) == 1) begin
        m_owner = gt[0] ? 1 : (gt[1] ? 2 : 3);
        m_sent  = 0;
        m_fin   = 0;
      end else if ($countones(gt) > 1) begin
        m_em = 1;
      end
    end else if (!m_fin) begin
      if (!gt[m_owner-1]) begin
        m_ea = 1; m_owner = 0;
      end else if (rdy) begin
        m_sent++;
        if (lst[m_owner-1] || m_sent == MAXB) m_fin = 1;
      end
    end else if (!gt[m_owner-1]) begin
      m_owner = 0; m_fin = 0;
    end
  endtask

  task automatic check(input string nm, input out_t a, input out_t e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic tick(input string nm, output out_t act);
    @(negedge clk);
    act = dut_o;
    check(nm, act, model_out());
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl [11];
    out_t act;
    int   nack, nval, n3;
    bit   prev_stall;
    logic [7:0] prev_d;
    bit   pat [6] = '{1, 0, 0, 1, 1, 1};

    tbl[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, mk(0, 8'h00, 2'd0, 3'b000, 3'b000, 0, 0)};
    tbl[1]  = '{1'b0, 3'b010, 3'b010, 1'b1, mk(0, 8'h00, 2'd0, 3'b000, 3'b000, 0, 0)};
    tbl[2]  = '{1'b0, 3'b010, 3'b010, 1'b1, mk(1, 8'hA5, 2'd2, 3'b010, 3'b000, 0, 0)};
    tbl[3]  = '{1'b0, 3'b010, 3'b010, 1'b1, mk(0, 8'h00, 2'd2, 3'b000, 3'b010, 0, 0)};
    tbl[4]  = '{1'b0, 3'b010, 3'b000, 1'b1, mk(0, 8'h00, 2'd2, 3'b000, 3'b010, 0, 0)};
    tbl[5]  = '{1'b0, 3'b000, 3'b000, 1'b1, mk(0, 8'h00, 2'd2, 3'b000, 3'b010, 0, 0)};
    tbl[6]  = '{1'b0, 3'b011, 3'b000, 1'b1, mk(0, 8'h00, 2'd0, 3'b000, 3'b000, 0, 0)};
    tbl[7]  = '{1'b0, 3'b000, 3'b000, 1'b1, mk(0, 8'h00, 2'd0, 3'b000, 3'b000, 1, 0)};
    tbl[8]  = '{1'b0, 3'b000, 3'b000, 1'b0, mk(0, 8'h00, 2'd0, 3'b000, 3'b000, 1, 0)};
    tbl[9]  = '{1'b1, 3'b000, 3'b000, 1'b0, mk(0, 8'h00, 2'd0, 3'b000, 3'b000, 1, 0)};
    tbl[10] = '{1'b0, 3'b000, 3'b000, 1'b0, mk(0, 8'h00, 2'd0, 3'b000, 3'b000, 0, 0)};

    dv[0] = 8'h11; dv[1] = 8'hA5; dv[2] = 8'h33;
    @(posedge clk);
    #1;
    m_owner = 0; m_sent = 0; m_fin = 0; m_em = 0; m_ea = 0;

    // Directed table: reset, single-word burst on source 2, multi-grant error.
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; gt = tbl[i].gt; lst = tbl[i].lst; rdy = tbl[i].rdy;
      tick("tbl_model", act);
      check($sformatf("tbl_row%0d", i), act, tbl[i].exp);
    end
    rst = 1'b0;

    // Source 1 never signals last: burst capped at MAX_BURST words.
    gt = 3'b001; lst = '0; rdy = 1'b1; nack = 0; nval = 0;
    for (int i = 0; i < 8; i++) begin
      dv[0] = 8'($urandom);
      tick("burst_max", act);
      nack += int'(act[5]);
      nval += int'(act[18]);
    end
    check("burst_acks", out_t'(nack), out_t'(MAXB));
    check("burst_words", out_t'(nval), out_t'(MAXB));
    check("burst_done1", out_t'(act[2]), out_t'(1));

    // Exit DONE, then a new grant: first word two cycles after exit.
    gt = 3'b000;
    tick("done_exit", act);
    gt = 3'b010; lst = 3'b010; dv[1] = 8'h5C;
    tick("regrant_idle", act);
    check("regrant_gap", out_t'(act[18]), out_t'(0));
    tick("regrant_xfer", act);
    check("regrant_word", out_t'({act[18], act[17:10]}), out_t'({1'b1, 8'h5C}));
    tick("regrant_done", act);
    gt = 3'b000; lst = '0;
    tick("regrant_exit", act);
    tick("regrant_rest", act);

    // Source 3 with a stalling sink: data holds while not accepted.
    gt = 3'b100; rdy = 1'b0; dv[2] = 8'h40; n3 = 0; prev_stall = 0; prev_d = '0;
    tick("stall_idle", act);
    for (int i = 0; i < 6; i++) begin
      rdy = pat[i];
      tick("stall_burst", act);
      if (prev_stall) check("stall_hold", out_t'(act[17:10]), out_t'(prev_d));
      prev_stall = act[18] && !rdy;
      prev_d     = act[17:10];
      if (act[7]) begin
        n3++;
        dv[2] = dv[2] + 8'd1;
      end
    end
    check("stall_acks", out_t'(n3), out_t'(4));
    tick("stall_done", act);
    check("stall_done3", out_t'(act[4]), out_t'(1));
    gt = 3'b000;
    tick("stall_exit", act);
    tick("stall_rest", act);

    // Grant 2 withdrawn mid-burst after two words.
    gt = 3'b010; rdy = 1'b1; lst = '0;
    tick("abort_idle", act);
    tick("abort_w1", act);
    tick("abort_w2", act);
    gt = 3'b000;
    tick("abort_cycle", act);
    check("abort_noack", out_t'({act[6], act[3]}), out_t'(0));
    tick("abort_after", act);
    check("abort_flag", out_t'({act[0], act[3], act[9:8]}), out_t'({1'b1, 1'b0, 2'd0}));

    // Reset in the middle of a source-1 burst.
    gt = 3'b001;
    tick("rst_idle", act);
    tick("rst_w1", act);
    tick("rst_w2", act);
    rst = 1'b1;
    tick("rst_edge", act);
    rst = 1'b0;
    tick("rst_after", act);
    check("rst_mid", act, out_t'(0));
    gt = 3'b000;
    tick("rst_rest", act);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(3) == 0) begin
        r = int'($urandom_range(9));
        if (r < 6)      gt = 3'b001 << $urandom_range(2);
        else if (r < 8) gt = 3'b000;
        else            gt = 3'($urandom);
      end
      lst   = 3'($urandom) & 3'($urandom);
      rdy   = 1'($urandom);
      dv[0] = 8'($urandom); dv[1] = 8'($urandom); dv[2] = 8'($urandom);
      tick("random", act);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
